// File: rtl/ui_pkg.sv
// Shared types and constants for the board-game UI renderer test harness.
// Holds the controller state enum, track/flag geometry, VGA timing and colours.
package ui_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        MOVING       = 3'd1,
        JUMPING      = 3'd2,
        FLAG_SLIDING = 3'd3
    } state_t;

    localparam logic [9:0] TILE_W     = 10'd60;
    localparam logic [9:0] START_X    = 10'd20;
    localparam logic [9:0] FLAG_X     = 10'd620;
    localparam logic [9:0] BASE_Y     = 10'd124;
    localparam logic [9:0] GROUND_Y   = 10'd144;

    localparam logic [9:0] FLAG_Y_TOP = 10'd40;
    localparam logic [9:0] FLAG_Y_END = 10'd112;
    localparam logic [9:0] FLAG_L     = 10'd604;
    localparam logic [9:0] FLAG_H     = 10'd12;
    localparam logic [9:0] POLE_L     = 10'd620;
    localparam logic [9:0] POLE_R     = 10'd623;
    localparam logic [9:0] POLE_BOT   = 10'd123;

    localparam logic [9:0] H_VIS      = 10'd640;
    localparam logic [9:0] H_SYNC_S   = 10'd656;
    localparam logic [9:0] H_SYNC_E   = 10'd751;
    localparam logic [9:0] H_TOTAL    = 10'd800;
    localparam logic [9:0] V_VIS      = 10'd480;
    localparam logic [9:0] V_SYNC_S   = 10'd490;
    localparam logic [9:0] V_SYNC_E   = 10'd491;
    localparam logic [9:0] V_TOTAL    = 10'd525;

    localparam logic [11:0] COL_TOKEN = 12'hF00;
    localparam logic [11:0] COL_FLAG  = 12'hFF0;
    localparam logic [11:0] COL_POLE  = 12'hFFF;
    localparam logic [11:0] COL_TILE  = 12'hA50;
    localparam logic [11:0] COL_GRASS = 12'h0A0;
    localparam logic [11:0] COL_SKY   = 12'h5AF;

    // Destination n tiles ahead, clipped at the flag pole.
    function automatic logic [9:0] clip_target(input logic [9:0] x,
                                               input logic [2:0] n);
        logic [10:0] sum;
        sum = {1'b0, x} + 11'(TILE_W) * 11'(n);
        return (sum > 11'(FLAG_X)) ? FLAG_X : sum[9:0];
    endfunction

endpackage

// File: rtl/debounce.sv
// Button debouncer: 2-flop synchroniser then a stable-high counter.
// Ports: clk, rst_n, clear (forces released), din (raw), dout (debounced level).
module debounce
    import ui_pkg::*;
#(
    parameter int CYCLES = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic din,
    output logic dout
);
    localparam int W = $clog2(CYCLES + 1);

    logic         s0, s1;
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s0 <= din;
            s1 <= s0;
            if (clear || !s1) begin
                cnt  <= '0;
                dout <= 1'b0;
            end else if (cnt == W'(CYCLES - 1)) begin
                dout <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ui_ctrl.sv
// Token animation controller: move, jump arc and end-of-track flag slide.
// Ports: clk, rst_n, restart, pos_valid/active_player/target_x request in;
// player1_x/y, fsm_state, flag_y, flag_done, turn_done out.
module ui_ctrl
    import ui_pkg::*;
#(
    parameter int STEP_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       pos_valid,
    input  logic       active_player,
    input  logic [9:0] target_x,
    output logic [9:0] player1_x,
    output logic [9:0] player1_y,
    output logic [2:0] fsm_state,
    output logic [9:0] flag_y,
    output logic       flag_done,
    output logic       turn_done
);
    localparam int SW = $clog2(STEP_CYCLES + 1);

    state_t        state, state_n;
    logic [4:0]    counter, counter_n;
    logic [9:0]    x_n, target, target_n, flag_y_n;
    logic          flag_done_n, turn_done_n;
    logic [SW-1:0] step_cnt;
    logic          step_tick;
    logic [9:0]    prod, jump_offset, current_y;

    assign step_tick   = (step_cnt == SW'(STEP_CYCLES - 1));
    assign prod        = 10'(counter) * (10'd31 - 10'(counter));
    assign jump_offset = prod >> 3;
    assign current_y   = BASE_Y - jump_offset;
    assign player1_y   = current_y;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state     <= IDLE;
            player1_x <= START_X;
            counter   <= '0;
            target    <= START_X;
            flag_y    <= FLAG_Y_TOP;
            flag_done <= 1'b0;
            turn_done <= 1'b0;
            step_cnt  <= '0;
        end else begin
            state     <= state_n;
            player1_x <= x_n;
            counter   <= counter_n;
            target    <= target_n;
            flag_y    <= flag_y_n;
            flag_done <= flag_done_n;
            turn_done <= turn_done_n;
            // Step timer restarts from zero at the start of every turn.
            if (state == IDLE || step_tick) step_cnt <= '0;
            else                            step_cnt <= step_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        x_n         = player1_x;
        counter_n   = counter;
        target_n    = target;
        flag_y_n    = flag_y;
        flag_done_n = flag_done;
        turn_done_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (pos_valid && !active_player) begin
                    target_n = target_x;
                    state_n  = MOVING;
                end
            end
            MOVING: begin
                if (step_tick) begin
                    counter_n = '0;
                    if (player1_x >= target) begin
                        state_n = JUMPING;
                    end else begin
                        x_n = player1_x + 10'd1;
                        if (x_n == target) state_n = JUMPING;
                    end
                end
            end
            JUMPING: begin
                if (step_tick) begin
                    if (counter == 5'd31) begin
                        counter_n = '0;
                        if (player1_x == FLAG_X && !flag_done) begin
                            state_n = FLAG_SLIDING;
                        end else begin
                            turn_done_n = 1'b1;
                            state_n     = IDLE;
                        end
                    end else begin
                        counter_n = counter + 5'd1;
                    end
                end
            end
            FLAG_SLIDING: begin
                if (step_tick) begin
                    flag_y_n = flag_y + 10'd1;
                    if (flag_y_n == FLAG_Y_END) begin
                        flag_done_n = 1'b1;
                        turn_done_n = 1'b1;
                        state_n     = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: rtl/ui_render.sv
// 640x480 VGA scene renderer: timing counters, pixel priority mux, and the
// animation controller. Ports: request in, turn_done/player1_x/fsm_state/
// flag_done out, 4-bit RGB and active-low syncs.
module ui_render
    import ui_pkg::*;
#(
    parameter int STEP_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       pos_valid,
    input  logic       active_player,
    input  logic [9:0] target_x,
    output logic       turn_done,
    output logic [9:0] player1_x,
    output logic [2:0] fsm_state,
    output logic       flag_done,
    output logic [3:0] vgaRed,
    output logic [3:0] vgaGreen,
    output logic [3:0] vgaBlue,
    output logic       Hsync,
    output logic       Vsync
);
    logic [9:0]  player1_y, flag_y;
    logic [1:0]  div;
    logic [9:0]  hcnt, vcnt;
    logic [11:0] pix, rgb;
    logic        tile_hit;

    ui_ctrl #(.STEP_CYCLES(STEP_CYCLES)) ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .restart       (restart),
        .pos_valid     (pos_valid),
        .active_player (active_player),
        .target_x      (target_x),
        .player1_x     (player1_x),
        .player1_y     (player1_y),
        .fsm_state     (fsm_state),
        .flag_y        (flag_y),
        .flag_done     (flag_done),
        .turn_done     (turn_done)
    );

    always_comb begin
        tile_hit = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (int'(hcnt) >= 20 + 60 * k - 25 &&
                int'(hcnt) <= 20 + 60 * k + 25)
                tile_hit = 1'b1;
        end
    end

    // Offsets are added to the counter side so nothing underflows.
    always_comb begin
        pix = COL_SKY;
        if (hcnt + 10'd10 >= player1_x && hcnt <= player1_x + 10'd9 &&
            vcnt + 10'd20 >= player1_y && vcnt < player1_y)
            pix = COL_TOKEN;
        else if (hcnt >= FLAG_L && hcnt < FLAG_X &&
                 vcnt >= flag_y && vcnt < flag_y + FLAG_H)
            pix = COL_FLAG;
        else if (hcnt >= POLE_L && hcnt <= POLE_R &&
                 vcnt >= FLAG_Y_TOP && vcnt <= POLE_BOT)
            pix = COL_POLE;
        else if (vcnt >= BASE_Y && vcnt < GROUND_Y && tile_hit)
            pix = COL_TILE;
        else if (vcnt >= GROUND_Y)
            pix = COL_GRASS;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div   <= '0;
            hcnt  <= '0;
            vcnt  <= '0;
            rgb   <= '0;
            Hsync <= 1'b1;
            Vsync <= 1'b1;
        end else begin
            div <= div + 2'd1;
            if (div == 2'd3) begin
                if (hcnt == H_TOTAL - 10'd1) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_TOTAL - 10'd1) ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
            rgb   <= (hcnt < H_VIS && vcnt < V_VIS) ? pix : 12'h000;
            Hsync <= !(hcnt >= H_SYNC_S && hcnt <= H_SYNC_E);
            Vsync <= !(vcnt >= V_SYNC_S && vcnt <= V_SYNC_E);
        end
    end

    assign vgaRed   = rgb[11:8];
    assign vgaGreen = rgb[7:4];
    assign vgaBlue  = rgb[3:0];
endmodule

// File: rtl/ui_render_test_top.sv
// Board-level harness: debounced buttons issue move requests to the renderer
// in place of game logic. Ports: clk, rst_n, btnC/L/U/R/D, VGA RGB/syncs, led.
module ui_render_test_top
    import ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int STEP_CYCLES     = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnC,
    input  logic       btnL,
    input  logic       btnU,
    input  logic       btnR,
    input  logic       btnD,
    output logic [3:0] vgaRed,
    output logic [3:0] vgaGreen,
    output logic [3:0] vgaBlue,
    output logic       Hsync,
    output logic       Vsync,
    output logic [3:0] led
);
    logic [4:0] btn_raw, btn_db;
    logic [4:1] btn_q, rise;
    logic       restart, busy;
    logic [2:0] n_tiles, fsm_state;
    logic [9:0] player1_x, player1_pos_x_sim;
    logic       pos_valid_sim, active_player_sim, turn_done, flag_done;

    assign btn_raw = {btnD, btnR, btnU, btnL, btnC};

    for (genvar i = 0; i < 5; i++) begin : g_db
        debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .clear ((i == 0) ? 1'b0 : restart),
            .din   (btn_raw[i]),
            .dout  (btn_db[i])
        );
    end

    assign restart           = btn_db[0];
    assign active_player_sim = 1'b0;
    assign rise              = btn_db[4:1] & ~btn_q;

    // Shortest move wins when several buttons rise together.
    always_comb begin
        n_tiles = 3'd4;
        if      (rise[1]) n_tiles = 3'd1;
        else if (rise[2]) n_tiles = 3'd2;
        else if (rise[3]) n_tiles = 3'd3;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) btn_q <= '0;
        else        btn_q <= btn_db[4:1];
    end

    // busy spans request to turn_done so a press can never queue behind a turn.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            pos_valid_sim     <= 1'b0;
            player1_pos_x_sim <= START_X;
            busy              <= 1'b0;
        end else begin
            pos_valid_sim <= 1'b0;
            if (turn_done) busy <= 1'b0;
            if (|rise && fsm_state == IDLE && !busy && !pos_valid_sim) begin
                pos_valid_sim     <= 1'b1;
                player1_pos_x_sim <= clip_target(player1_x, n_tiles);
                busy              <= 1'b1;
            end
        end
    end

    ui_render #(.STEP_CYCLES(STEP_CYCLES)) ui (
        .clk           (clk),
        .rst_n         (rst_n),
        .restart       (restart),
        .pos_valid     (pos_valid_sim),
        .active_player (active_player_sim),
        .target_x      (player1_pos_x_sim),
        .turn_done     (turn_done),
        .player1_x     (player1_x),
        .fsm_state     (fsm_state),
        .flag_done     (flag_done),
        .vgaRed        (vgaRed),
        .vgaGreen      (vgaGreen),
        .vgaBlue       (vgaBlue),
        .Hsync         (Hsync),
        .Vsync         (Vsync)
    );

    assign led = {flag_done, fsm_state};
endmodule

// File: tb/tb_ui_render_test_top.sv
// Scoreboard bench for ui_render_test_top: button moves, jump peak, flag
// slide, restart, simultaneous press and horizontal VGA timing.
module tb_ui_render_test_top;
    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnC = 0, btnL = 0, btnU = 0, btnR = 0, btnD = 0;
    logic [3:0] vgaRed, vgaGreen, vgaBlue, led;
    logic       Hsync, Vsync;

    always #5 clk = ~clk;

    ui_render_test_top #(.DEBOUNCE_CYCLES(50), .STEP_CYCLES(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .btnC(btnC), .btnL(btnL), .btnU(btnU),
        .btnR(btnR), .btnD(btnD), .vgaRed(vgaRed), .vgaGreen(vgaGreen),
        .vgaBlue(vgaBlue), .Hsync(Hsync), .Vsync(Vsync), .led(led)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int target;
        bit flag;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   mx = 20;
    bit   mflag = 0;

    int  cyc = 0, t_pv = 0, done_cnt = 0, pv_len = 0, td_len = 0;
    bit  in_turn = 0, saw_mv = 0, saw_jp = 0, saw_fl = 0, peak_done = 0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (dut.pos_valid_sim) begin
                pv_len++;
                if (in_turn) chk("pv_dropped", 1, 0);
                else if (sb.size() == 0) chk("pv_unexpected", 1, 0);
                else begin
                    chk("pv_target", dut.player1_pos_x_sim, sb[0].target);
                    chk("pv_player", dut.active_player_sim, 0);
                    t_pv = cyc; in_turn = 1;
                    saw_mv = 0; saw_jp = 0; saw_fl = 0;
                end
            end else if (pv_len != 0) begin
                chk("pv_width", pv_len, 1);
                pv_len = 0;
            end
            if (led[2:0] == 3'd1) saw_mv = 1;
            if (led[2:0] == 3'd2) saw_jp = 1;
            if (led[2:0] == 3'd3) saw_fl = 1;
            if (!peak_done && dut.ui.ctrl.state == 3'd2 &&
                dut.ui.ctrl.counter == 5'd15) begin
                chk("peak_y", dut.ui.ctrl.current_y, 94);
                peak_done = 1;
            end
            if (dut.turn_done) begin
                td_len++;
                if (sb.size() == 0 || !in_turn) chk("td_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    in_turn = 0;
                    chk("td_x", dut.ui.ctrl.player1_x, e.target);
                    chk("td_y", dut.ui.ctrl.player1_y, 124);
                    chk("td_seq", {saw_mv, saw_jp}, 2'b11);
                    chk("td_flagpath", saw_fl, e.flag);
                    chk("td_latency", cyc - t_pv, e.lat);
                    chk("td_flagdone", led[3], (e.target == 620) ? 1 : 0);
                    if (e.flag) chk("flag_y_end", dut.ui.ctrl.flag_y, 112);
                    done_cnt++;
                end
            end else if (td_len != 0) begin
                chk("td_width", td_len, 1);
                td_len = 0;
            end
        end
    end

    // mask bits: 0=L(1 tile) 1=U(2) 2=R(3) 3=D(4)
    task automatic press(input logic [3:0] mask, input bit intrude);
        exp_t e;
        int   n, d, start;
        n = mask[0] ? 1 : mask[1] ? 2 : mask[2] ? 3 : 4;
        e.target = (mx + 60 * n > 620) ? 620 : mx + 60 * n;
        d = e.target - mx;
        e.flag = (e.target == 620) && !mflag;
        e.lat = 1 + STEP * (((d == 0) ? 1 : d) + 32 + (e.flag ? 72 : 0));
        if (e.flag) mflag = 1;
        mx = e.target;
        sb.push_back(e);
        start = done_cnt;
        {btnD, btnR, btnU, btnL} = mask;
        repeat (100) @(negedge clk);
        {btnD, btnR, btnU, btnL} = 4'b0;
        if (intrude) begin
            repeat (5) @(negedge clk);
            btnR = 1;
            repeat (80) @(negedge clk);
            btnR = 0;
        end
        for (int i = 0; i < 20000 && done_cnt == start; i++) @(negedge clk);
        if (done_cnt == start) chk("td_timeout", 0, 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_hs(input logic lvl, output time t);
        t = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (Hsync === lvl) begin
                t = $time;
                break;
            end
        end
        if (t == 0) chk("hsync_timeout", 0, 1);
    endtask

    initial begin
        time t0, t1, t2;
        repeat (10) @(negedge clk);
        chk("rst_x", dut.ui.ctrl.player1_x, 20);
        chk("rst_y", dut.ui.ctrl.player1_y, 124);
        chk("rst_state", led, 0);
        chk("rst_syncs", {Hsync, Vsync}, 2'b11);
        chk("rst_rgb", {vgaRed, vgaGreen, vgaBlue}, 0);
        chk("rst_pv", dut.pos_valid_sim, 0);
        rst_n = 1;
        repeat (5) @(negedge clk);

        press(4'b0001, 0);
        press(4'b0010, 1);
        press(4'b0100, 0);
        press(4'b0001, 0);
        press(4'b0010, 0);
        press(4'b0001, 0);
        chk("flag_led", led[3], 1);
        press(4'b0001, 0);

        btnC = 1;
        repeat (100) @(negedge clk);
        btnC = 0;
        repeat (10) @(negedge clk);
        chk("rs_x", dut.ui.ctrl.player1_x, 20);
        chk("rs_flag_y", dut.ui.ctrl.flag_y, 40);
        chk("rs_led", led, 0);
        mx = 20; mflag = 0;
        press(4'b1001, 0);

        wait_hs(1'b1, t0);
        wait_hs(1'b0, t0);
        repeat (100) @(negedge clk);
        chk("blank_rgb", {vgaRed, vgaGreen, vgaBlue}, 0);
        wait_hs(1'b1, t1);
        wait_hs(1'b0, t2);
        chk("hsync_low", 32'((t1 - t0) / 10), 384);
        chk("hsync_period", 32'((t2 - t0) / 10), 3200);
        chk("vsync_idle", Vsync, 1);
        for (int i = 0; i < 4000 && dut.ui.hcnt != 10'd100; i++)
            @(negedge clk);
        @(negedge clk);
        chk("sky_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h5AF);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
